// File: rtl/projection_scheduler_if.sv
// Signal bundle for the projection scheduler: frame config, vertex memory port,
// shared projector inputs/outputs and the screen-triangle stream to the rasterizer.
interface projection_scheduler_if #(
  parameter int unsigned VW   = 16,
  parameter int unsigned IDXW = 10,
  parameter int unsigned SW   = 10
);
  logic                start;
  logic [IDXW-1:0]     num_tris;
  logic [16*VW-1:0]    mvp_in;
  logic [SW-1:0]       width_in;
  logic [SW-1:0]       height_in;
  logic                busy;
  logic                done;
  logic [IDXW-1:0]     tri_addr;
  logic                tri_rd;
  logic [12*VW-1:0]    tri_rdata;
  logic [4*VW-1:0]     proj_va;
  logic [4*VW-1:0]     proj_vb;
  logic [4*VW-1:0]     proj_vc;
  logic [16*VW-1:0]    proj_mvp;
  logic [SW-1:0]       proj_width;
  logic [SW-1:0]       proj_height;
  logic [2*SW-1:0]     proj_V1;
  logic [2*SW-1:0]     proj_V2;
  logic [2*SW-1:0]     proj_V3;
  logic                out_valid;
  logic                out_ready;
  logic [2*SW-1:0]     out_V1;
  logic [2*SW-1:0]     out_V2;
  logic [2*SW-1:0]     out_V3;
  logic [IDXW-1:0]     out_idx;

  // Scheduler side.
  modport master (
    input  start, num_tris, mvp_in, width_in, height_in, tri_rdata,
           proj_V1, proj_V2, proj_V3, out_ready,
    output busy, done, tri_addr, tri_rd, proj_va, proj_vb, proj_vc,
           proj_mvp, proj_width, proj_height, out_valid, out_V1, out_V2, out_V3, out_idx
  );

  // Environment side: host, vertex memory, projector and rasterizer.
  modport slave (
    output start, num_tris, mvp_in, width_in, height_in, tri_rdata,
           proj_V1, proj_V2, proj_V3, out_ready,
    input  busy, done, tri_addr, tri_rd, proj_va, proj_vb, proj_vc,
           proj_mvp, proj_width, proj_height, out_valid, out_V1, out_V2, out_V3, out_idx
  );
endinterface

// File: rtl/projection_scheduler.sv
// Frame sequencer for the shared combinational triangle projector: fetches each
// triangle, holds it on the projector for SETTLE cycles, then streams the result.
module projection_scheduler #(
  parameter int unsigned VW     = 16,
  parameter int unsigned IDXW   = 10,
  parameter int unsigned SW     = 10,
  parameter int unsigned SETTLE = 3   // 1..15
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  projection_scheduler_if.master bus
);
  localparam logic [3:0] SettleLast = 4'(SETTLE - 1);

  typedef enum logic [2:0] {StIdle, StFetch, StLoad, StWait, StEmit, StDone} state_e;

  state_e           r_state, w_state_next;
  logic [IDXW-1:0]  r_count;
  logic [IDXW-1:0]  r_idx, w_idx_next;
  logic [IDXW-1:0]  r_tri_addr;
  logic [3:0]       r_settle;
  logic [4*VW-1:0]  r_va, r_vb, r_vc;
  logic [16*VW-1:0] r_mvp;
  logic [SW-1:0]    r_width, r_height;
  logic             r_out_valid;
  logic [2*SW-1:0]  r_out_v1, r_out_v2, r_out_v3;
  logic [IDXW-1:0]  r_out_idx;
  logic             w_last, w_settled, w_handshake;

  assign w_last      = (r_idx == r_count - IDXW'(1));
  assign w_settled   = (r_settle == SettleLast);
  assign w_handshake = r_out_valid & bus.out_ready;

  always_ff @(posedge Clk) begin
    if (!Reset_n) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_idx_next   = '0;
          w_state_next = (bus.num_tris == '0) ? StDone : StFetch;
        end
      end
      StFetch: w_state_next = StLoad;
      StLoad:  w_state_next = StWait;
      StWait:  if (w_settled) w_state_next = StEmit;
      StEmit: begin
        if (w_handshake) begin
          if (w_last) begin
            w_state_next = StDone;
          end else begin
            w_idx_next   = r_idx + IDXW'(1);
            w_state_next = StFetch;
          end
        end
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_count     <= '0;
      r_idx       <= '0;
      r_tri_addr  <= '0;
      r_settle    <= '0;
      r_va        <= '0;
      r_vb        <= '0;
      r_vc        <= '0;
      r_mvp       <= '0;
      r_width     <= '0;
      r_height    <= '0;
      r_out_valid <= 1'b0;
      r_out_v1    <= '0;
      r_out_v2    <= '0;
      r_out_v3    <= '0;
      r_out_idx   <= '0;
    end else begin
      r_idx <= w_idx_next;
      // Address only moves when a fetch is about to be issued.
      if (w_state_next == StFetch) r_tri_addr <= w_idx_next;
      case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_count  <= bus.num_tris;
            r_mvp    <= bus.mvp_in;
            r_width  <= bus.width_in;
            r_height <= bus.height_in;
          end
        end
        StLoad: begin
          r_va     <= bus.tri_rdata[4*VW-1:0];
          r_vb     <= bus.tri_rdata[8*VW-1:4*VW];
          r_vc     <= bus.tri_rdata[12*VW-1:8*VW];
          r_settle <= '0;
        end
        StWait: begin
          r_settle <= r_settle + 4'd1;
          if (w_settled) begin
            r_out_v1    <= bus.proj_V1;
            r_out_v2    <= bus.proj_V2;
            r_out_v3    <= bus.proj_V3;
            r_out_idx   <= r_idx;
            r_out_valid <= 1'b1;
          end
        end
        StEmit:  if (bus.out_ready) r_out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.busy        = (r_state != StIdle) && (r_state != StDone);
  assign bus.done        = (r_state == StDone);
  assign bus.tri_rd      = (r_state == StFetch);
  assign bus.tri_addr    = r_tri_addr;
  assign bus.proj_va     = r_va;
  assign bus.proj_vb     = r_vb;
  assign bus.proj_vc     = r_vc;
  assign bus.proj_mvp    = r_mvp;
  assign bus.proj_width  = r_width;
  assign bus.proj_height = r_height;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_V1      = r_out_v1;
  assign bus.out_V2      = r_out_v2;
  assign bus.out_V3      = r_out_v3;
  assign bus.out_idx     = r_out_idx;
endmodule

// File: tb/tb_projection_scheduler.sv
// Bench for projection_scheduler: vertex memory and projector models, a table of
// frame scenarios, a mid-frame reset sequence and randomized frames.
module tb_projection_scheduler;
  localparam int unsigned VW     = 16;
  localparam int unsigned IDXW   = 10;
  localparam int unsigned SW     = 10;
  localparam int unsigned SETTLE = 3;
  localparam int          P      = 3 + SETTLE;

  logic Clk;
  logic Reset_n;
  int   n_checks;
  int   n_errors;
  int   seed;
  logic [16*VW-1:0] cfg_mvp;
  logic [SW-1:0]    cfg_w;
  logic [SW-1:0]    cfg_h;
  int   stall_of [0:63];

  projection_scheduler_if #(.VW(VW), .IDXW(IDXW), .SW(SW)) bus ();

  projection_scheduler #(.VW(VW), .IDXW(IDXW), .SW(SW), .SETTLE(SETTLE)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [VW-1:0] mem_elem(input int k, input int e);
    return VW'(k * 37 + e * 1009 + seed * 101);
  endfunction

  function automatic logic [12*VW-1:0] mem_word(input logic [IDXW-1:0] a);
    logic [12*VW-1:0] w;
    for (int e = 0; e < 12; e++) w[e*VW +: VW] = mem_elem(int'(a), e);
    return w;
  endfunction

  // Vertex memory: one-cycle read latency; otherwise the data bus keeps toggling.
  always @(posedge Clk) begin
    if (bus.tri_rd) bus.tri_rdata <= mem_word(bus.tri_addr);
    else            bus.tri_rdata <= ~bus.tri_rdata;
  end

  // Projector stand-in: folds vertex x/y (and config) into screen coordinates.
  assign bus.proj_V1 = {bus.proj_va[VW+SW-1:VW], bus.proj_va[SW-1:0]} ^
                       {bus.proj_height, bus.proj_width};
  assign bus.proj_V2 = {bus.proj_vb[VW+SW-1:VW], bus.proj_vb[SW-1:0]} ^ bus.proj_mvp[2*SW-1:0];
  assign bus.proj_V3 = {bus.proj_vc[VW+SW-1:VW], bus.proj_vc[SW-1:0]} ^
                       {bus.proj_vc[3*VW+SW-1:3*VW], bus.proj_vc[2*VW+SW-1:2*VW]};

  // Reference: screen vertex j of triangle k straight from memory contents and frame config.
  function automatic logic [2*SW-1:0] exp_v(input int k, input int j);
    logic [2*SW-1:0] r;
    case (j)
      1:       r = {SW'(mem_elem(k, 1)), SW'(mem_elem(k, 0))} ^ {cfg_h, cfg_w};
      2:       r = {SW'(mem_elem(k, 5)), SW'(mem_elem(k, 4))} ^ cfg_mvp[2*SW-1:0];
      default: r = {SW'(mem_elem(k, 9)), SW'(mem_elem(k, 8))} ^
                   {SW'(mem_elem(k, 11)), SW'(mem_elem(k, 10))};
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic new_cfg();
    for (int j = 0; j < 8; j++) cfg_mvp[j*32 +: 32] = $urandom;
    cfg_w = SW'($urandom);
    cfg_h = SW'($urandom);
    for (int j = 0; j < 64; j++) stall_of[j] = 0;
  endtask

  // Entered and left at a negedge with the DUT idle. exp_done < 0 derives it from the model.
  task automatic run_frame(input int n, input int poke_c, input int exp_done);
    int c, emitted, fetched, last_hs, stall_left, want_done;
    bit have_valid, busy_bad, done_seen;
    logic [IDXW+6*SW-1:0] held;
    bus.start     = 1'b1;
    bus.num_tris  = IDXW'(n);
    bus.mvp_in    = cfg_mvp;
    bus.width_in  = cfg_w;
    bus.height_in = cfg_h;
    c = 0; emitted = 0; fetched = 0; last_hs = 0;
    have_valid = 1'b0; busy_bad = 1'b0; done_seen = 1'b0;
    held = '0;
    stall_left = stall_of[0];
    while (!done_seen && c < 2000) begin
      @(negedge Clk);
      c++;
      if (c == poke_c && bus.busy) begin
        bus.start    = 1'b1;
        bus.num_tris = IDXW'(n + 5);
        bus.mvp_in   = ~cfg_mvp;
        bus.width_in = ~cfg_w;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.tri_rd) begin
        chk("tri_addr", 256'(bus.tri_addr), 256'(fetched));
        chk("rd_during_valid", 256'(bus.out_valid), 256'(0));
        fetched++;
      end
      if (bus.out_valid) begin
        if (!have_valid) begin
          chk("valid_cycle", 256'(c), 256'(last_hs + P));
          held = {bus.out_idx, bus.out_V1, bus.out_V2, bus.out_V3};
          have_valid = 1'b1;
        end else begin
          chk("stall_hold", 256'({bus.out_idx, bus.out_V1, bus.out_V2, bus.out_V3}), 256'(held));
        end
        if (stall_left > 0) begin
          bus.out_ready = 1'b0;
          stall_left--;
        end else begin
          bus.out_ready = 1'b1;
          chk("out_idx", 256'(bus.out_idx), 256'(emitted));
          chk("out_V1", 256'(bus.out_V1), 256'(exp_v(emitted, 1)));
          chk("out_V2", 256'(bus.out_V2), 256'(exp_v(emitted, 2)));
          chk("out_V3", 256'(bus.out_V3), 256'(exp_v(emitted, 3)));
          chk("proj_mvp", bus.proj_mvp, cfg_mvp);
          chk("proj_wh", 256'({bus.proj_height, bus.proj_width}), 256'({cfg_h, cfg_w}));
          emitted++;
          last_hs    = c;
          have_valid = 1'b0;
          stall_left = (emitted < 64) ? stall_of[emitted] : 0;
        end
      end else begin
        bus.out_ready = 1'($urandom);
      end
      if (bus.done) begin
        done_seen = 1'b1;
        want_done = (exp_done >= 0) ? exp_done : ((n == 0) ? 1 : last_hs + 1);
        chk("done_cycle", 256'(c), 256'(want_done));
        chk("emitted", 256'(emitted), 256'(n));
        chk("fetched", 256'(fetched), 256'(n));
        chk("busy_at_done", 256'(bus.busy), 256'(0));
      end else if (!bus.busy) begin
        busy_bad = 1'b1;
      end
    end
    if (!done_seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout: done not seen within %0d cycles (n=%0d)", c, n);
    end
    chk("busy_in_frame", 256'(busy_bad), 256'(0));
    bus.start = 1'b0;
    @(negedge Clk);
    chk("done_one_cycle", 256'(bus.done), 256'(0));
    chk("idle_busy", 256'(bus.busy), 256'(0));
  endtask

  typedef struct {
    int n;
    int stall_tri;
    int stall_len;
    int poke_c;
    int exp_done;
  } vec_t;

  vec_t vecs [0:5];
  bit   flag;

  initial begin
    n_checks = 0;
    n_errors = 0;
    seed     = 0;
    // num_tris, stalled triangle, stall length, mid-frame start cycle, done cycle
    vecs[0] = '{3, -1, 0, 0, 19};
    vecs[1] = '{3,  1, 5, 0, 24};
    vecs[2] = '{0, -1, 0, 0, 1};
    vecs[3] = '{3, -1, 0, 4, 19};
    vecs[4] = '{1, -1, 0, 0, 7};
    vecs[5] = '{2,  0, 2, 3, 15};

    Reset_n       = 1'b0;
    bus.start     = 1'b0;
    bus.num_tris  = '0;
    bus.mvp_in    = '0;
    bus.width_in  = '0;
    bus.height_in = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;

    flag = 1'b0;
    repeat (10) begin
      @(negedge Clk);
      if (bus.tri_rd || bus.busy || bus.done || bus.out_valid) flag = 1'b1;
    end
    chk("idle_activity", 256'(flag), 256'(0));
    chk("rst_tri_addr", 256'(bus.tri_addr), 256'(0));
    chk("rst_out", 256'({bus.out_idx, bus.out_V1, bus.out_V2, bus.out_V3}), 256'(0));
    chk("rst_proj_v", 256'({bus.proj_va, bus.proj_vb, bus.proj_vc}), 256'(0));
    chk("rst_proj_cfg", bus.proj_mvp | 256'({bus.proj_width, bus.proj_height}), 256'(0));

    for (int i = 0; i < 6; i++) begin
      seed = i + 1;
      new_cfg();
      if (vecs[i].stall_tri >= 0) stall_of[vecs[i].stall_tri] = vecs[i].stall_len;
      run_frame(vecs[i].n, vecs[i].poke_c, vecs[i].exp_done);
    end

    // Reset during the settle window of triangle 1.
    seed = 11;
    new_cfg();
    bus.start     = 1'b1;
    bus.num_tris  = IDXW'(3);
    bus.mvp_in    = cfg_mvp;
    bus.width_in  = cfg_w;
    bus.height_in = cfg_h;
    bus.out_ready = 1'b1;
    @(negedge Clk);
    bus.start = 1'b0;
    repeat (8) @(negedge Clk);
    chk("pre_reset_busy", 256'(bus.busy), 256'(1));
    chk("pre_reset_idx", 256'(bus.out_idx), 256'(0));
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    chk("reset_busy", 256'(bus.busy), 256'(0));
    chk("reset_valid", 256'(bus.out_valid), 256'(0));
    chk("reset_proj", 256'({bus.proj_va, bus.proj_width}) | bus.proj_mvp, 256'(0));
    flag = 1'b0;
    repeat (10) begin
      @(negedge Clk);
      if (bus.out_valid || bus.tri_rd || bus.busy) flag = 1'b1;
    end
    chk("post_reset_quiet", 256'(flag), 256'(0));
    seed = 12;
    new_cfg();
    run_frame(1, 0, 7);

    for (int i = 0; i < 10; i++) begin
      seed = int'($urandom_range(1, 1000));
      new_cfg();
      for (int j = 0; j < 8; j++) stall_of[j] = int'($urandom_range(0, 3));
      run_frame(int'($urandom_range(0, 7)), int'($urandom_range(0, 12)), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/projection_scheduler.md
Name: projection_scheduler

Overview:
- Frame-level sequencer for the shared combinational triangle projector (MVP transform, perspective divide, viewport map).
- On `start` it latches the frame configuration (MVP, viewport width/height) and walks the triangle list in vertex memory.
- Per triangle: fetch → register vertices into the projector inputs → wait a fixed settle window (multicycle path) → emit screen-space vertices on a valid/ready stream to the rasterizer.

Parameters:
- VW, 16, vertex/matrix element width (Q8.8 fixed point).
- IDXW, 10, triangle index/address width.
- SW, 10, screen coordinate and viewport dimension width.
- SETTLE, 3, cycles the projector inputs are held stable before outputs are sampled; legal range 1..15.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle frame start request.
- num_tris  in  IDXW  triangle count, sampled on accepted start.
- mvp_in  in  16*VW  MVP matrix, row-major, sampled on accepted start.
- width_in  in  SW  viewport width, sampled on accepted start.
- height_in  in  SW  viewport height, sampled on accepted start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at frame completion.
- tri_addr  out  IDXW  triangle index to vertex memory.
- tri_rd  out  1  read strobe; data is returned exactly 1 cycle later.
- tri_rdata  in  12*VW  {vc,vb,va}, each {w,z,y,x}, va in LSBs.
- proj_va, proj_vb, proj_vc  out  4*VW each  registered projector vertex inputs.
- proj_mvp  out  16*VW  registered projector matrix.
- proj_width, proj_height  out  SW each  registered projector viewport.
- proj_V1, proj_V2, proj_V3  in  2*SW each  projector outputs {y,x}.
- out_valid  out  1  screen triangle available.
- out_ready  in  1  rasterizer accepts.
- out_V1, out_V2, out_V3  out  2*SW each  captured screen vertices.
- out_idx  out  IDXW  index of the emitted triangle.

Behaviour:
- Reset (Reset_n low at a Clk edge): all outputs and registers are 0, FSM goes to IDLE. This applies mid-frame; no pending triangle is emitted afterwards.
- States: IDLE, FETCH, LOAD, WAIT, EMIT, DONE.
- IDLE:
  - start=1 latches num_tris, mvp_in, width_in and height_in into proj_mvp/proj_width/proj_height and an internal count; idx=0; busy=1.
  - If num_tris==0 → DONE; else → FETCH.
- start while not in IDLE is ignored; latched config is never altered mid-frame.
- FETCH: tri_rd=1 for exactly one cycle, tri_addr=idx → LOAD.
- LOAD: capture tri_rdata into proj_va/vb/vc; clear settle counter → WAIT.
- WAIT: counter increments each cycle. When counter==SETTLE-1, capture proj_V1/V2/V3 into out_V1..3, set out_idx=idx and out_valid=1 → EMIT.
- EMIT:
  - out_valid stays high; out_V*/out_idx stay stable until out_ready=1.
  - On handshake: out_valid=0. If idx==count-1 → DONE; else idx+1 → FETCH (same cycle transition).
  - proj_va/vb/vc are held unchanged through EMIT.
- DONE: done=1 for one cycle, busy=0 → IDLE. start may be accepted in the following cycle.
- Throughput: with out_ready held high, one triangle every 3+SETTLE cycles. Latency from start to first out_valid is 3+SETTLE cycles.
- idx counts up to count-1 only; there is no wrap. Max count is 2^IDXW-1.
- tri_addr holds its last value outside FETCH. tri_rd is 0 except in FETCH.
- No arithmetic on vertex data; projector output is passed through unmodified.

Test Plan:
- Reset, then idle for 10 cycles → all outputs 0, busy=0, no tri_rd.
- SETTLE=3, num_tris=3, out_ready=1, memory model returns distinct vertices per index, projector model echoes {idx,idx} → out_idx 0,1,2 on cycles 6,12,18 after start; done pulses once; busy falls with done.
- Same frame with out_ready low for 5 cycles on triangle 1 → out_valid held, out_V*/out_idx stable, no tri_rd during the stall; sequence completes with correct order.
- num_tris=0 → done pulse the cycle after start, no tri_rd, no out_valid.
- start pulsed again mid-frame with a different mvp_in → proj_mvp unchanged, frame completes with the original count.
- Reset_n low during WAIT of triangle 1 → next cycle IDLE, out_valid=0, busy=0; a new start with num_tris=1 emits idx 0 normally.
